// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead FIFO with valid/ready drain
module uart_rx_fifo #(
  parameter int WAIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] r_data,
  output logic       r_valid,
  input  logic       r_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(WAIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF = CW'(WAIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic s1, rx_s, push, ferr, pop, full, wr;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full    = count == (AW + 1)'(DEPTH);
  assign r_valid = count != '0;
  assign pop     = r_valid && r_ready;
  assign wr      = push && (!full || pop);
  assign r_data  = mem[rd_ptr];
  // two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk)
    if (reset) {s1, rx_s} <= 2'b11;
    else {s1, rx_s} <= {uart_rx, s1};
  // receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  // frame sequencing: mid-bit start check, full-bit data/stop sampling
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt == HALF) begin
          state_n = rx_s ? IDLE : DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          cnt_n     = '0;
          sh_n[idx] = rx_s;
          idx_n     = idx + 1'b1;
          state_n   = idx == 3'd7 ? STOP : DATA;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          cnt_n   = '0;
          push    = rx_s;
          ferr    = !rx_s;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // FIFO storage; pointers alone define validity so no reset is needed
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= sh;
  // FIFO pointers, occupancy and error pulses
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(wr);
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
      frame_err <= ferr;
      overrun   <= push && full && !pop;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic r_ready = 1'b0;
  logic [7:0] r_data;
  logic r_valid, frame_err, overrun;
  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe0, ov0;

  uart_rx_fifo #(.WAIT(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .r_data(r_data),
    .r_valid(r_valid), .r_ready(r_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // count high cycles of the error pulses
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one 8N1 frame, 8 clocks per bit, pin falls 1ns after a rising edge
  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1 uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk);
      #1 uart_rx = d[i];
    end
    repeat (8) @(posedge clk);
    #1 uart_rx = stop;
    repeat (8) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (16) @(posedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] e);
    @(negedge clk);
    chk({tag, "_valid"}, r_valid, 1);
    chk({tag, "_data"}, r_data, e);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  task automatic snap;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", r_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    repeat (200) @(posedge clk);

    // basic frame with exact push latency
    snap();
    fork
      send_byte(8'h0F, 1'b1);
      begin
        repeat (79) @(posedge clk);
        #1 chk("lat_before", r_valid, 0);
        @(posedge clk);
        #1 chk("lat_at", r_valid, 1);
        chk("basic_data", r_data, 8'h0F);
      end
    join
    chk("basic_fe", fe_cnt - fe0, 0);
    chk("basic_ov", ov_cnt - ov0, 0);
    pop_chk("basic_pop", 8'h0F);
    chk("basic_empty", r_valid, 0);

    // glitch shorter than half a bit
    snap();
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("glitch_valid", r_valid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    // framing error then a good frame
    snap();
    send_byte(8'hA5, 1'b0);
    chk("ferr_pulse", fe_cnt - fe0, 1);
    chk("ferr_valid", r_valid, 0);
    chk("ferr_ov", ov_cnt - ov0, 0);
    send_byte(8'h3C, 1'b1);
    pop_chk("after_ferr", 8'h3C);
    chk("after_ferr_empty", r_valid, 0);

    // fill and overrun
    snap();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_fe", fe_cnt - fe0, 0);
    for (int i = 1; i <= 4; i++) pop_chk("ovr_drain", 8'(i));
    @(negedge clk);
    chk("ovr_empty", r_valid, 0);

    // push and pop on the same edge while full
    snap();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    fork
      send_byte(8'h05, 1'b1);
      begin
        repeat (79) @(posedge clk);
        #1 r_ready = 1'b1;
        @(posedge clk);
        #1 r_ready = 1'b0;
      end
    join
    chk("simul_ov", ov_cnt - ov0, 0);
    for (int i = 2; i <= 5; i++) pop_chk("simul_drain", 8'(i));
    @(negedge clk);
    chk("simul_empty", r_valid, 0);

    // reset during data bit 4 with two bytes queued
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("pre_rst_valid", r_valid, 1);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (45) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_flush", r_valid, 0);
      end
    join
    chk("rst_nopush", r_valid, 0);
    send_byte(8'h5A, 1'b1);
    pop_chk("post_rst", 8'h5A);
    chk("post_rst_empty", r_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end of `mother_board`. It consumes the raw `uart_rx` pin driven by the host or testbench, deserialises 8N1 frames at `WAIT` clocks per bit and queues the received bytes in a small show-ahead FIFO. The CPU-side I/O logic drains the FIFO through a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `WAIT`, 8: clocks per UART bit. Must be even and ≥ 4.
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `uart_rx`, input, 1: asynchronous serial line. Idle level is 1.
- `r_data`, output, 8: FIFO head byte. Valid only while `r_valid` is high.
- `r_valid`, output, 1: FIFO not empty.
- `r_ready`, input, 1: consumer accepts the head this cycle.
- `frame_err`, output, 1: one-cycle pulse; the stop bit was sampled as 0.
- `overrun`, output, 1: one-cycle pulse; a good byte was dropped because the FIFO was full.

## Operation
- **Synchroniser.** `uart_rx` passes through 2 flops. Both reset to 1. The output is `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP. Counter `cnt` is $clog2(WAIT) bits. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **IDLE:** if `rx_s`==0, go to START and set `cnt`=0.
- **START:** increment `cnt`.
  - At `cnt`==WAIT/2-1, evaluate `rx_s`.
  - If `rx_s`==0: go to DATA with `cnt`=0, `idx`=0.
  - If `rx_s`==1: the start was a glitch; go to IDLE. No flag is raised.
- **DATA:** at `cnt`==WAIT-1, set `sh[idx]`=`rx_s` (LSB first) and `cnt`=0.
  - After `idx`==7 is sampled, go to STOP.
  - Otherwise increment `idx`.
- **STOP:** at `cnt`==WAIT-1, evaluate `rx_s`.
  - If `rx_s`==1: push `sh` into the FIFO.
  - If `rx_s`==0: pulse `frame_err` and discard the byte.
  - Either way, go to IDLE. A new falling edge can therefore be detected from the next cycle.
- **FIFO:** `DEPTH` entries with read/write pointers of $clog2(DEPTH) bits. Pointers wrap naturally. An occupancy counter has $clog2(DEPTH)+1 bits.
  - `r_data` always shows `mem[rd_ptr]` (show-ahead, no read latency).
  - Pop occurs when `r_valid && r_ready`. `r_ready` while empty is ignored.
  - Push while full with no pop in the same cycle: the byte is dropped and `overrun` pulses. FIFO contents are unchanged.
  - Push while full with a pop in the same cycle: both happen and the count stays at DEPTH. No overrun.
  - Push and pop together when not full: both happen and the count is unchanged.
- A framing error never writes the FIFO and never raises `overrun`.

## Timing
- **Reset values:**
  - FSM: IDLE. `cnt`, `idx`, `sh`: 0. Synchroniser flops: 1.
  - FIFO pointers and count: 0.
  - `r_valid`=0, `frame_err`=0, `overrun`=0. `r_data` = `mem[0]` (don't-care while invalid).
- **Frame timing:**
  - Let E0 be the clock edge at which IDLE sees `rx_s`==0. This is 2–3 edges after the pin falls, due to the synchroniser.
  - The start bit is checked at E0+WAIT/2.
  - Data bit k is sampled at E0+WAIT/2+(k+1)·WAIT.
  - The stop bit is checked at E0+WAIT/2+9·WAIT.
- **Output latency:**
  - The push occurs on the stop-check edge. `r_valid` is high from that edge onward; for WAIT=8 that is E0+76.
  - `frame_err` and `overrun` are high for exactly the one cycle following the stop-check edge.
- **Handshake:** after a pop edge, `r_data` shows the next entry in the same cycle. `r_valid` drops after the pop edge that empties the FIFO.
- **Reset mid-frame:** `reset` asserted on any edge aborts the frame and flushes the FIFO. The next frame is received normally if its start occurs after `reset` deasserts.
- **Line held low:** a continuous break (line held at 0) yields `frame_err` once per 0.5+9 bit times plus re-detection, back to back. It produces no FIFO writes.

## Test plan
- **Basic frame.** WAIT=8. After 2000 ns idle, drive start bit 0, data 1,1,1,1,0,0,0,0 (LSB first), stop bit 1, 80 ns per bit. Expected: exactly one push, `r_data`=8'h0F, `r_valid` high, no flags.
- **Glitch rejection.** Drive `uart_rx` low for 2 clocks, then back high. Expected: FSM returns to IDLE, no push, no `frame_err`.
- **Framing error.** Send 8'hA5 with the stop bit driven 0. Expected: one `frame_err` pulse, `r_valid` stays 0. A following good frame with 8'h3C is received correctly.
- **Fill and overrun.** Hold `r_ready`=0 and send 5 bytes 8'h01–8'h05 with DEPTH=4. Expected: one `overrun` pulse on the 5th byte; draining then yields 01, 02, 03, 04 and `r_valid` drops.
- **Simultaneous push/pop while full.** Fill to 4 entries, then assert `r_ready` on the 5th byte's stop-check edge. Expected: no overrun; drain order 02, 03, 04, 05.
- **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 4 of a frame, with 2 bytes queued. Expected: `r_valid`=0 and no push from the aborted frame; the next full frame, 8'h5A, is received correctly.
